// File: rtl/setup_menu_param_if.sv
// Keypad/display bundle between the packet source, the setup menu and the lock core.
// The keypad side is the master; the setup block is the slave.
interface setup_menu_param_if #(
  parameter int NUM_CFG       = 8,
  parameter int FIELD_DIGITS  = 4,
  parameter int BUF_DIGITS    = 20,
  parameter int MASTER_DIGITS = 4
);
  logic                               setup_on;
  logic [MASTER_DIGITS*4-1:0]         master_pw;
  logic [BUF_DIGITS*4-1:0]            digitos_value;
  logic                               digitos_valid;
  logic                               display_en;
  logic [7:0]                         bcd_idx;
  logic [FIELD_DIGITS*4-1:0]          bcd_val;
  logic [NUM_CFG*FIELD_DIGITS*4-1:0]  data_setup_new;
  logic                               data_setup_ok;
  logic                               setup_err;

  modport master (
    output setup_on, master_pw, digitos_value, digitos_valid,
    input  display_en, bcd_idx, bcd_val, data_setup_new, data_setup_ok, setup_err
  );

  modport slave (
    input  setup_on, master_pw, digitos_value, digitos_valid,
    output display_en, bcd_idx, bcd_val, data_setup_new, data_setup_ok, setup_err
  );
endinterface

// File: rtl/setup_menu_param.sv
// Password-gated editor for NUM_CFG BCD fields; the edited set is committed
// atomically to data_setup_new or discarded on cancel, timeout or auth failure.
module setup_menu_param #(
  parameter int NUM_CFG        = 8,
  parameter int FIELD_DIGITS   = 4,
  parameter int BUF_DIGITS     = 20,
  parameter int MASTER_DIGITS  = 4,
  parameter int MAX_TRIES      = 3,
  parameter int TIMEOUT_CYCLES = 5000,
  parameter logic [NUM_CFG*FIELD_DIGITS*4-1:0] DEFAULTS = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  setup_menu_param_if.slave  bus
);

  localparam int FW = FIELD_DIGITS * 4;
  localparam int CW = NUM_CFG * FW;
  localparam int NW = $clog2(BUF_DIGITS + 1);
  localparam int IW = 7;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_AUTH   = 2'd1,
    S_EDIT   = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t         r_state;
  logic [IW-1:0]  r_idx;
  logic [RW-1:0]  r_tries;
  logic [TW-1:0]  r_tmo;
  logic [CW-1:0]  r_work;
  logic [CW-1:0]  r_cfg;
  logic           r_display_en;
  logic [7:0]     r_bcd_idx;
  logic [FW-1:0]  r_bcd_val;
  logic           r_ok;
  logic           r_err;

  logic [3:0]             w_key;
  logic                   w_star;
  logic                   w_hash;
  logic [BUF_DIGITS-2:0]  w_nz;
  logic [NW-1:0]          w_n;
  logic                   w_run;
  logic [FW-1:0]          w_entry;
  logic                   w_pw_ok;
  logic                   w_timeout;
  logic                   w_too_long;
  logic                   w_last;
  logic [FW-1:0]          w_cur;

  function automatic logic [FW-1:0] field_of(input logic [CW-1:0] set, input int k);
    logic [FW-1:0] res;
    res = '0;
    if (k >= 0 && k < NUM_CFG) begin
      res = set[k*FW +: FW];
    end
    return res;
  endfunction

  function automatic logic [7:0] to_bcd(input int k);
    return {4'(k / 10), 4'(k % 10)};
  endfunction

  assign w_key  = bus.digitos_value[3:0];
  assign w_star = bus.digitos_valid && (w_key == 4'hA);
  assign w_hash = bus.digitos_valid && (w_key == 4'hB);

  // Nibbles above the key; the entry length is the run of non-empty ones.
  genvar gi;
  generate
    for (gi = 0; gi < BUF_DIGITS - 1; gi++) begin : g_nz
      assign w_nz[gi] = (bus.digitos_value[(gi+1)*4 +: 4] != 4'hF);
    end
  endgenerate

  always_comb begin
    w_n   = '0;
    w_run = 1'b1;
    for (int k = 0; k < BUF_DIGITS - 1; k++) begin
      if (w_run && w_nz[k]) begin
        w_n = w_n + 1'b1;
      end else begin
        w_run = 1'b0;
      end
    end
  end

  // Typed digits zero-extended to a full field; nibble 1 is the least-significant digit.
  generate
    for (gi = 0; gi < FIELD_DIGITS; gi++) begin : g_entry
      assign w_entry[gi*4 +: 4] = (NW'(gi) < w_n) ? bus.digitos_value[(gi+1)*4 +: 4] : 4'h0;
    end
  endgenerate

  assign w_pw_ok    = (w_n == NW'(MASTER_DIGITS)) &&
                      (bus.digitos_value[4 +: MASTER_DIGITS*4] == bus.master_pw);
  assign w_timeout  = !bus.digitos_valid && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_too_long = (w_n > NW'(FIELD_DIGITS));
  assign w_last     = (r_idx == IW'(NUM_CFG - 1));
  assign w_cur      = field_of(r_work, int'(r_idx));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_tries      <= '0;
      r_tmo        <= '0;
      r_work       <= '0;
      r_cfg        <= DEFAULTS;
      r_display_en <= 1'b0;
      r_bcd_idx    <= 8'h00;
      r_bcd_val    <= '0;
      r_ok         <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_ok  <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_display_en <= 1'b0;
          r_bcd_idx    <= 8'h00;
          r_bcd_val    <= '0;
          if (bus.setup_on) begin
            r_state      <= S_AUTH;
            r_tries      <= '0;
            r_tmo        <= '0;
            r_work       <= r_cfg;
            r_display_en <= 1'b1;
          end
        end

        S_AUTH: begin
          r_tmo <= bus.digitos_valid ? '0 : r_tmo + 1'b1;
          if (w_star && w_pw_ok) begin
            r_state   <= S_EDIT;
            r_idx     <= '0;
            r_bcd_idx <= to_bcd(1);
            r_bcd_val <= field_of(r_work, 0);
          end else if (w_star) begin
            r_err <= 1'b1;
            if (r_tries == RW'(MAX_TRIES - 1)) begin
              r_state      <= S_IDLE;
              r_display_en <= 1'b0;
            end else begin
              r_tries <= r_tries + 1'b1;
            end
          end else if (w_hash || w_timeout) begin
            r_err        <= 1'b1;
            r_state      <= S_IDLE;
            r_display_en <= 1'b0;
          end
        end

        S_EDIT: begin
          r_tmo <= bus.digitos_valid ? '0 : r_tmo + 1'b1;
          if (w_star && w_too_long) begin
            r_err <= 1'b1;
          end else if (w_star) begin
            if (w_n != '0) begin
              r_work[int'(r_idx)*FW +: FW] <= w_entry;
            end
            if (w_last) begin
              r_state   <= S_COMMIT;
              r_bcd_val <= (w_n != '0) ? w_entry : w_cur;
            end else begin
              r_idx     <= r_idx + 1'b1;
              r_bcd_idx <= to_bcd(int'(r_idx) + 2);
              r_bcd_val <= field_of(r_work, int'(r_idx) + 1);
            end
          end else if (w_hash && (w_n == '0) && (r_idx != '0)) begin
            r_idx     <= r_idx - 1'b1;
            r_bcd_idx <= to_bcd(int'(r_idx));
            r_bcd_val <= field_of(r_work, int'(r_idx) - 1);
          end else if ((w_hash && (w_n == '0)) || w_timeout) begin
            // Cancel at the first field, or inactivity: the working copy is simply abandoned.
            r_err        <= 1'b1;
            r_state      <= S_IDLE;
            r_display_en <= 1'b0;
            r_bcd_idx    <= 8'h00;
            r_bcd_val    <= '0;
          end
        end

        S_COMMIT: begin
          r_cfg        <= r_work;
          r_ok         <= 1'b1;
          r_state      <= S_IDLE;
          r_display_en <= 1'b0;
          r_bcd_idx    <= 8'h00;
          r_bcd_val    <= '0;
        end

        default: begin
          r_state      <= S_IDLE;
          r_display_en <= 1'b0;
        end
      endcase
    end
  end

  assign bus.display_en     = r_display_en;
  assign bus.bcd_idx        = r_bcd_idx;
  assign bus.bcd_val        = r_bcd_val;
  assign bus.data_setup_new = r_cfg;
  assign bus.data_setup_ok  = r_ok;
  assign bus.setup_err      = r_err;

endmodule

// File: tb/tb_setup_menu_param.sv
// Randomized bench for setup_menu_param against a key-level reference model of
// the setup menu (modes, field list, try counter) plus directed boundary cases.
module tb_setup_menu_param;

  localparam int NC = 8;
  localparam int FD = 4;
  localparam int BD = 20;
  localparam int MD = 4;
  localparam int MT = 3;
  localparam int TO = 5000;
  localparam int FW = FD * 4;
  localparam int CW = NC * FW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Model: mode 0 = idle, 1 = waiting for master password, 2 = editing.
  int              m_mode;
  int              m_idx;
  int              m_tries;
  logic [FW-1:0]   m_cfg  [NC];
  logic [FW-1:0]   m_work [NC];
  logic [MD*4-1:0] m_pw;

  always #5 clk = ~clk;

  setup_menu_param_if #(.NUM_CFG(NC), .FIELD_DIGITS(FD), .BUF_DIGITS(BD), .MASTER_DIGITS(MD)) bus ();

  setup_menu_param #(
    .NUM_CFG(NC), .FIELD_DIGITS(FD), .BUF_DIGITS(BD), .MASTER_DIGITS(MD),
    .MAX_TRIES(MT), .TIMEOUT_CYCLES(TO), .DEFAULTS('0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] idx_bcd(input int k);
    return {4'(k / 10), 4'(k % 10)};
  endfunction

  function automatic logic [CW-1:0] pack_cfg();
    logic [CW-1:0] r;
    for (int k = 0; k < NC; k++) r[k*FW +: FW] = m_cfg[k];
    return r;
  endfunction

  function automatic logic [31:0] rand_bcd(input int n);
    logic [31:0] v;
    v = '0;
    for (int j = 0; j < n; j++) v = (v << 4) | 32'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic check_all(input string tag, input bit e_err);
    check_val({tag, ".disp"}, bus.display_en, m_mode != 0);
    check_val({tag, ".idx"},  bus.bcd_idx, (m_mode == 2) ? idx_bcd(m_idx + 1) : 8'h00);
    check_val({tag, ".val"},  bus.bcd_val, (m_mode == 2) ? m_work[m_idx] : '0);
    check_val({tag, ".err"},  bus.setup_err, e_err);
    check_val({tag, ".ok"},   bus.data_setup_ok, 1'b0);
    check_val({tag, ".cfg"},  bus.data_setup_new, pack_cfg());
  endtask

  // val holds the typed digits as BCD in typing order (last typed = low nibble).
  task automatic model_strobe(input int key, input int n, input logic [31:0] val,
                              output bit e_err, output bit e_commit);
    e_err    = 1'b0;
    e_commit = 1'b0;
    if (m_mode == 1) begin
      if (key == 10) begin
        if (n == MD && val[MD*4-1:0] == m_pw) begin
          m_mode = 2;
          m_idx  = 0;
        end else begin
          e_err = 1'b1;
          m_tries++;
          if (m_tries >= MT) m_mode = 0;
        end
      end else if (key == 11) begin
        e_err  = 1'b1;
        m_mode = 0;
      end
    end else if (m_mode == 2) begin
      if (key == 10) begin
        if (n > FD) begin
          e_err = 1'b1;
        end else begin
          if (n > 0) m_work[m_idx] = val[FW-1:0];
          if (m_idx == NC - 1) begin
            e_commit = 1'b1;
            m_mode   = 0;
          end else begin
            m_idx++;
          end
        end
      end else if (key == 11 && n == 0) begin
        if (m_idx > 0) begin
          m_idx--;
        end else begin
          e_err  = 1'b1;
          m_mode = 0;
        end
      end
    end
  endtask

  // Called at a falling edge; drives one strobe and checks after the next rising edge.
  task automatic press(input string tag, input int key, input int n, input logic [31:0] val);
    logic [BD*4-1:0] p;
    bit e_err;
    bit e_commit;
    p = '1;
    p[3:0] = 4'(key);
    for (int j = 0; j < n; j++) p[(j+1)*4 +: 4] = val[j*4 +: 4];
    if (n + 2 < BD) p[(n+2)*4 +: 4] = 4'($urandom_range(0, 9));
    bus.digitos_value = p;
    bus.digitos_valid = 1'b1;
    model_strobe(key, n, val, e_err, e_commit);
    @(negedge clk);
    bus.digitos_valid = 1'b0;
    $display("[%0t] %s key=%h n=%0d val=%h -> disp=%b idx=%h bcd=%h err=%b",
             $time, tag, key, n, val, bus.display_en, bus.bcd_idx, bus.bcd_val, bus.setup_err);
    if (e_commit) begin
      check_val({tag, ".c_disp"}, bus.display_en, 1'b1);
      check_val({tag, ".c_ok0"},  bus.data_setup_ok, 1'b0);
      check_val({tag, ".c_cfg0"}, bus.data_setup_new, pack_cfg());
      @(negedge clk);
      for (int k = 0; k < NC; k++) m_cfg[k] = m_work[k];
      check_val({tag, ".c_ok"},   bus.data_setup_ok, 1'b1);
      check_val({tag, ".c_disp"}, bus.display_en, 1'b0);
      check_val({tag, ".c_err"},  bus.setup_err, 1'b0);
      check_val({tag, ".c_cfg"},  bus.data_setup_new, pack_cfg());
      $display("[%0t] %s commit cfg=%h", $time, tag, bus.data_setup_new);
    end else begin
      check_all(tag, e_err);
    end
  endtask

  task automatic enter(input string tag);
    bus.setup_on = 1'b1;
    if (m_mode == 0) begin
      m_mode  = 1;
      m_tries = 0;
      for (int k = 0; k < NC; k++) m_work[k] = m_cfg[k];
    end
    @(negedge clk);
    bus.setup_on = 1'b0;
    $display("[%0t] %s setup_on -> disp=%b idx=%h", $time, tag, bus.display_en, bus.bcd_idx);
    check_all(tag, 1'b0);
  endtask

  task automatic finish_edit(input string tag);
    for (int g = 0; g < NC + 1 && m_mode == 2; g++) press(tag, 10, 0, 0);
  endtask

  initial begin
    int n;
    int op;
    bus.setup_on      = 1'b0;
    bus.digitos_valid = 1'b0;
    bus.digitos_value = '1;
    bus.master_pw     = 16'h1234;
    m_pw    = 16'h1234;
    m_mode  = 0;
    m_idx   = 0;
    m_tries = 0;
    for (int k = 0; k < NC; k++) begin
      m_cfg[k]  = '0;
      m_work[k] = '0;
    end

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Authentication and a pass over every field with no edits.
    enter("t1_enter");
    press("t1_auth", 10, 4, 32'h1234);
    check_val("t1_idx", bus.bcd_idx, 8'h01);
    for (int i = 0; i < NC; i++) begin
      press("t2_star", 10, 0, 0);
      if (i < NC - 1) check_val("t2_idx", bus.bcd_idx, idx_bcd(i + 2));
    end
    check_val("t2_cfg", bus.data_setup_new, '0);

    // Writes survive backward navigation.
    enter("t3_enter");
    press("t3_auth", 10, 4, 32'h1234);
    press("t3_f0", 10, 1, 32'h5);
    press("t3_f1", 10, 2, 32'h42);
    press("t3_back", 11, 0, 0);
    press("t3_back", 11, 0, 0);
    check_val("t3_idx", bus.bcd_idx, 8'h01);
    finish_edit("t3_star");
    check_val("t3_cfg", bus.data_setup_new, 128'h0042_0005);

    // Master failures up to the try limit.
    enter("t4_enter");
    for (int i = 0; i < MT; i++) press("t4_bad", 10, 4, 32'h9999);
    check_val("t4_disp", bus.display_en, 1'b0);

    // Over-long entry, then cancel at the first field.
    enter("t5_enter");
    press("t5_auth", 10, 4, 32'h1234);
    press("t5_long", 10, 5, 32'h12345);
    check_val("t5_idx", bus.bcd_idx, 8'h01);
    press("t5_cancel", 11, 0, 0);
    check_val("t5_cfg", bus.data_setup_new, 128'h0042_0005);

    // Inactivity timeout while waiting for the password.
    enter("t6_enter");
    repeat (TO - 1) @(negedge clk);
    check_all("t6_pre", 1'b0);
    @(negedge clk);
    m_mode = 0;
    check_all("t6_tmo", 1'b1);

    // A strobe on the timeout edge keeps the session alive; edits are lost on timeout.
    enter("t6b_enter");
    press("t6b_auth", 10, 4, 32'h1234);
    press("t6b_f0", 10, 2, 32'h77);
    repeat (TO - 1) @(negedge clk);
    press("t6b_coin", 3, 0, 0);
    repeat (TO - 1) @(negedge clk);
    check_all("t6b_pre", 1'b0);
    @(negedge clk);
    m_mode = 0;
    check_all("t6b_tmo", 1'b1);

    // Randomized sessions.
    for (int s = 0; s < 30; s++) begin
      m_pw = rand_bcd(MD);
      bus.master_pw = m_pw;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      enter("r_enter");
      for (int a = 0; a < 5 && m_mode == 1; a++) begin
        op = $urandom_range(0, 9);
        if (op < 7)       press("r_auth", 10, MD, 32'(m_pw));
        else if (op == 7) press("r_auth", 10, MD, rand_bcd(MD));
        else if (op == 8) begin
          n = ($urandom_range(0, 1) == 0) ? MD - 1 : MD + 1;
          press("r_auth", 10, n, rand_bcd(n));
        end else          press("r_abort", 11, 0, 0);
      end
      for (int e = 0; e < 40 && m_mode == 2; e++) begin
        op = $urandom_range(0, 9);
        if (op <= 5) begin
          n = ($urandom_range(0, 5) == 0) ? FD + 1 : $urandom_range(0, FD);
          press("r_star", 10, n, rand_bcd(n));
        end else if (op <= 7) begin
          n = ($urandom_range(0, 2) == 0) ? $urandom_range(1, FD) : 0;
          press("r_hash", 11, n, rand_bcd(n));
        end else if (op == 8) begin
          n = $urandom_range(0, FD);
          press("r_digit", $urandom_range(0, 9), n, rand_bcd(n));
        end else begin
          enter("r_ignored");
        end
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      finish_edit("r_flush");
    end

    // Make the configuration non-default, then reset in the middle of an edit.
    m_pw = 16'h1234;
    bus.master_pw = m_pw;
    enter("t7_enter");
    press("t7_auth", 10, 4, 32'h1234);
    press("t7_f0", 10, 4, 32'h9876);
    finish_edit("t7_star");
    check_val("t7_cfg0", bus.data_setup_new[15:0], 16'h9876);
    enter("t7_enter2");
    press("t7_auth2", 10, 4, 32'h1234);
    press("t7_f0b", 10, 1, 32'h3);
    #2 rst_n = 1'b0;
    #1;
    m_mode = 0;
    for (int k = 0; k < NC; k++) m_cfg[k] = '0;
    check_all("t7_rst", 1'b0);
    @(negedge clk);
    check_all("t7_rst_hold", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    enter("t7_enter3");
    press("t7_auth3", 10, 4, 32'h1234);
    check_val("t7_val0", bus.bcd_val, 16'h0000);
    finish_edit("t7_star3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/setup_menu_param.md
# setup_menu_param

Parametrised successor to the lock's setup block. It sits between the keypad digit-packet source and the lock core. A `setup_on` pulse enters the mode, which is gated by the master password. The user then steps through `NUM_CFG` numeric fields and edits them, and the block either commits the whole field set atomically with a one-cycle `data_setup_ok` or discards it on cancel, timeout or auth failure. The block adds programmable field count and width, backward navigation, cancel, inactivity timeout and a lockout after repeated master failures.

## Interface
- `NUM_CFG`, 8: number of editable fields, 1..99.
- `FIELD_DIGITS`, 4: BCD digits per field, 1..8.
- `BUF_DIGITS`, 20: digits in the keypad packet, ≥ `FIELD_DIGITS`+1 and ≥ `MASTER_DIGITS`+1.
- `MASTER_DIGITS`, 4: master password length.
- `MAX_TRIES`, 3: master failures allowed before returning to IDLE.
- `TIMEOUT_CYCLES`, 5000: idle cycles in any active state before abort.
- `DEFAULTS`, all zero: reset value of `data_setup_new`, `NUM_CFG*FIELD_DIGITS*4` bits.
- `clk` in 1: clock.
- `rst` in 1: reset. Asynchronous assert, active-low.
- `setup_on` in 1: request to enter setup. Level; acted on only in IDLE.
- `master_pw` in `MASTER_DIGITS*4`: stored master password, BCD, most-significant digit first.
- `digitos_value` in `BUF_DIGITS*4`: keypad shift packet. Nibble 0 (bits 3:0) is the newest key; `0xF` means empty; `0xA` is `*`; `0xB` is `#`.
- `digitos_valid` in 1: one-cycle strobe, packet valid.
- `display_en` out 1: setup owns the display.
- `bcd_idx` out 8: current field index as 2 BCD digits. 0 in AUTH.
- `bcd_val` out `FIELD_DIGITS*4`: working value of the current field.
- `data_setup_new` out `NUM_CFG*FIELD_DIGITS*4`: committed configuration. Field k (0-based) occupies bits `[k*FIELD_DIGITS*4 +: FIELD_DIGITS*4]`.
- `data_setup_ok` out 1: one-cycle commit pulse.
- `setup_err` out 1: one-cycle pulse on rejected entry, auth failure, timeout or cancel.

## Operation
- States:
  - IDLE: `display_en`=0.
  - AUTH: `display_en`=1.
  - EDIT: `display_en`=1, `bcd_idx`=i+1.
  - COMMIT: one cycle.
- IDLE→AUTH when `setup_on`=1. Clears the try counter and the timeout counter, and loads the working copy from `data_setup_new`.
- Only strobes whose nibble 0 is `0xA` or `0xB` are acted on. Digit-only strobes only reset the timeout counter.
- Entered digits: nibbles 1..n, where n is the count of consecutive non-`0xF` nibbles above nibble 0. Nibble 1 is the least-significant digit.
- AUTH, `*`:
  - If n==`MASTER_DIGITS` and the digits equal `master_pw`, go to EDIT with i=0.
  - Otherwise pulse `setup_err` and increment tries. When tries reaches `MAX_TRIES`, go to IDLE.
- AUTH, `#`: abort to IDLE with a `setup_err` pulse.
- EDIT, `*`:
  - n=0: field unchanged.
  - 1≤n≤`FIELD_DIGITS`: the field gets the digits, zero-extended on the left.
  - n>`FIELD_DIGITS`: field unchanged, `setup_err` pulse, i stays.
  - Otherwise i advances. `*` at i=`NUM_CFG`-1 goes to COMMIT.
- EDIT, `#`:
  - n=0 and i>0: i decrements, no write.
  - n=0 and i=0: cancel. Discard the working copy, go to IDLE, pulse `setup_err`.
  - n>0: clear the typed entry only, with no state change.
- COMMIT: copy the working set to `data_setup_new`, pulse `data_setup_ok`, go to IDLE.
- Timeout: the counter increments every cycle in AUTH or EDIT and clears on any `digitos_valid`. At `TIMEOUT_CYCLES`-1 the block goes to IDLE, pulses `setup_err` and discards the working copy.
- `data_setup_new` changes only in COMMIT.

## Timing
- All outputs are registered. Reset values:
  - `display_en`=0, `bcd_idx`=0, `bcd_val`=0.
  - `data_setup_new`=`DEFAULTS`.
  - `data_setup_ok`=0, `setup_err`=0.
  - State IDLE, all counters 0.
- A strobe sampled at edge N is reflected in the state, `bcd_idx` and `bcd_val` after edge N.
- IDLE with `setup_on` at edge N: `display_en`=1 after edge N.
- COMMIT: on the last `*` at edge N, state is COMMIT after N. `data_setup_new` is updated and `data_setup_ok`=1 after N+1 for exactly one cycle, together with `display_en`=0.
- `setup_err` is high for one cycle after the offending edge.
- Reset during any state returns to IDLE immediately and restores `DEFAULTS`. No `data_setup_ok` pulse.
- A strobe coinciding with the timeout edge: the strobe wins and the counter clears.
- `setup_on` outside IDLE is ignored.

## Test plan
1. Reset, pulse `setup_on`, then keys `1 2 3 4 *` with `master_pw`=0x1234 → `display_en`=1, `bcd_idx`=0x01.
2. Continue with 8 bare `*` → `bcd_idx` steps 1..8. After the 8th, `data_setup_ok` pulses once, `data_setup_new`==`DEFAULTS`, `display_en`=0.
3. Auth, then `5 *`, then `4 2 *`, then `#` twice, then 8 `*` → `bcd_idx` goes back to 1 and commits. Field0=0x0005 and field1=0x0042, as written before the back-steps; rest default.
4. Wrong master `9 9 9 9 *` three times (`MAX_TRIES`=3) → three `setup_err` pulses, IDLE after the 3rd, no `data_setup_ok`.
5. Auth, `1 2 3 4 5 *` in field 0 → `setup_err`, `bcd_idx` stays 0x01. Then `#` at i=0 → IDLE, `data_setup_new` unchanged.
6. Auth, then idle for `TIMEOUT_CYCLES` → `setup_err` pulse, `display_en`=0. Separately, assert `rst` mid-EDIT → outputs at reset values immediately.
